// File: rtl/sr_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// sr_debounce_ctrl
//
// Command front end for an SR flip-flop. Two raw, bouncy push buttons are
// turned into clean single-cycle set/reset pulses. Each channel has its own
// synchroniser and debounce state machine. A pending flag per channel holds a
// request until the shared arbiter issues it. A holdoff counter keeps issued
// pulses apart, so the flip-flop never sees s and r high together.
//
// Parameters:
//   SYNC_STAGES      synchroniser depth per button (>= 2)
//   DEBOUNCE_CYCLES  stable synced cycles needed to accept a level (>= 1)
//   HOLDOFF_CYCLES   idle cycles forced after every issued pulse (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; release is sampled on clk
//   set_btn    raw set button (asynchronous, bouncy)
//   reset_btn  raw reset button (asynchronous, bouncy)
//   s          registered one-cycle set pulse
//   r          registered one-cycle reset pulse
//   conflict   one-cycle flag: simultaneous requests were dropped
//   busy       high while the holdoff window is running
//
// Build option:
//   SR_RESET_PRIORITY_EN  when defined, simultaneous requests issue r first
//                         and keep the set request for after the holdoff.
//                         When undefined, both are dropped and conflict
//                         pulses.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sr_debounce_channel
//
// One button channel: synchroniser plus a four-state debounce FSM.
//
// Ports:
//   clk, rst     as in the top level
//   btn          raw button input
//   event_pulse  high for one cycle when a new press has been qualified
// ---------------------------------------------------------------------------
module sr_debounce_channel #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic event_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_HELD,
      ST_RELEASE
   } db_state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   db_state_t              state;
   logic [CW-1:0]          cnt;

   // Shift chain that brings the asynchronous button into the clk domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Debounce FSM. ARM counts stable high cycles before a press is accepted.
   // RELEASE counts stable low cycles before the button may be pressed
   // again, so a short release bounce returns to HELD and gives no new event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (synced) begin
                  state <= ST_ARM;
                  cnt   <= CW'(1);
               end
            end
            ST_ARM: begin
               if (!synced) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= ST_HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!synced) begin
                  state <= ST_RELEASE;
                  cnt   <= CW'(1);
               end
            end
            ST_RELEASE: begin
               if (synced) begin
                  state <= ST_HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // The event is decoded from the ARM->HELD transition condition rather
   // than registered. This lets the arbiter register the output pulse on the
   // same edge that the FSM enters HELD, so no extra cycle of latency is added.
   assign event_pulse = (state == ST_ARM) && synced && (cnt == CNT_MAX);

endmodule

module sr_debounce_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic reset_btn,
   output logic s,
   output logic r,
   output logic conflict,
   output logic busy
);

   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

   logic          ev_set;
   logic          ev_reset;
   logic          pend_set;
   logic          pend_reset;
   logic          want_set;
   logic          want_reset;
   logic          can_issue;
   logic [HW-1:0] hold;

   sr_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_set_chan (
      .clk         (clk),
      .rst         (rst),
      .btn         (set_btn),
      .event_pulse (ev_set)
   );

   sr_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_reset_chan (
      .clk         (clk),
      .rst         (rst),
      .btn         (reset_btn),
      .event_pulse (ev_reset)
   );

   // A fresh event counts as pending in the same cycle it appears. An event
   // that lands while its flag is already set merges into the flag.
   assign want_set   = pend_set   | ev_set;
   assign want_reset = pend_reset | ev_reset;

   // The arbiter may issue once the holdoff counter has drained. busy is the
   // counter's non-zero state delayed by one cycle, so it covers the cycles
   // after the pulse and drops in the cycle of the next allowed pulse.
   assign can_issue = (hold == '0);

   // Pending flags, holdoff counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s          <= 1'b0;
         r          <= 1'b0;
         conflict   <= 1'b0;
         busy       <= 1'b0;
         pend_set   <= 1'b0;
         pend_reset <= 1'b0;
         hold       <= '0;
      end else begin
         s          <= 1'b0;
         r          <= 1'b0;
         conflict   <= 1'b0;
         busy       <= (hold != '0);
         pend_set   <= want_set;
         pend_reset <= want_reset;
         if (hold != '0) begin
            hold <= hold - 1'b1;
         end
         if (can_issue) begin
            if (want_set && !want_reset) begin
               s        <= 1'b1;
               pend_set <= 1'b0;
               hold     <= HOLD_LOAD;
            end else if (want_reset && !want_set) begin
               r          <= 1'b1;
               pend_reset <= 1'b0;
               hold       <= HOLD_LOAD;
            end else if (want_set && want_reset) begin
`ifdef SR_RESET_PRIORITY_EN
               r          <= 1'b1;
               pend_reset <= 1'b0;
               hold       <= HOLD_LOAD;
`else
               conflict   <= 1'b1;
               pend_set   <= 1'b0;
               pend_reset <= 1'b0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_debounce_ctrl
//
// Scoreboard bench for sr_debounce_ctrl. Stimulus pushes each expected pulse
// (kind and cycle) into a queue. A monitor on the falling edge pops an entry
// whenever s, r or conflict is seen and compares it. The monitor also checks
// busy against the holdoff window that follows each observed pulse, and checks
// that s and r are never high together.
// ---------------------------------------------------------------------------
module tb_sr_debounce_ctrl;

   localparam int SYNC     = 2;
   localparam int DEB      = 16;
   localparam int HOLD     = 4;
   // Drive at a falling edge in cycle c; first sample is at edge c+1; the
   // pulse is high in the cycle after edge c+1+SYNC+DEB.
   localparam int LAT      = 1 + SYNC + DEB;
   localparam int K_S      = 0;
   localparam int K_R      = 1;
   localparam int K_CONF   = 2;

   typedef struct {
      int kind;
      int cyc;
   } exp_t;

   logic clk;
   logic rst;
   logic set_btn;
   logic reset_btn;
   logic s;
   logic r;
   logic conflict;
   logic busy;

   int   cyc;
   int   tests_run;
   int   tests_failed;
   exp_t expq[$];

   // monitor-only state
   int   last_pulse;
   int   mon_kind;
   exp_t mon_e;
   logic mon_exp_busy;

   sr_debounce_ctrl #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .set_btn   (set_btn),
      .reset_btn (reset_btn),
      .s         (s),
      .r         (r),
      .conflict  (conflict),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kind_name(input int k);
      if (k == K_S) return "s";
      if (k == K_R) return "r";
      return "conflict";
   endfunction

   task automatic expect_pulse(input int kind, input int at_cyc);
      exp_t e;
      e.kind = kind;
      e.cyc  = at_cyc;
      expq.push_back(e);
   endtask

   task automatic apply_stimulus(input logic sv, input logic rv);
      set_btn   = sv;
      reset_btn = rv;
   endtask

   task automatic check_output(input string name, input logic act, input logic req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: pulse scoreboard, busy window and mutual exclusion.
   always @(negedge clk) begin
      if (!rst) begin
         last_pulse = -1000;
      end else begin
         if (s && r) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL exclusive: got s=1 r=1 at cycle %0d, required not both", cyc);
         end
         if (s || r || conflict) begin
            mon_kind = s ? K_S : (r ? K_R : K_CONF);
            tests_run++;
            if (expq.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL unexpected_pulse: got %s at cycle %0d, required none",
                        kind_name(mon_kind), cyc);
            end else begin
               mon_e = expq.pop_front();
               if (mon_e.kind != mon_kind || mon_e.cyc != cyc) begin
                  tests_failed++;
                  $display("[TB] FAIL pulse: got %s at cycle %0d, required %s at cycle %0d",
                           kind_name(mon_kind), cyc, kind_name(mon_e.kind), mon_e.cyc);
               end
            end
         end
         mon_exp_busy = ((cyc - last_pulse) >= 1) && ((cyc - last_pulse) <= HOLD);
         tests_run++;
         if (busy !== mon_exp_busy) begin
            tests_failed++;
            $display("[TB] FAIL busy: got %b at cycle %0d, required %b", busy, cyc, mon_exp_busy);
         end
         if (s || r) last_pulse = cyc;
      end
   end

   // Overall time bound.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int c;
      int k;
      tests_run    = 0;
      tests_failed = 0;
      last_pulse   = -1000;
      rst          = 1'b0;
      apply_stimulus(1'b0, 1'b0);

      // Reset state.
      wait_until(3);
      check_output("reset_s", s, 1'b0);
      check_output("reset_r", r, 1'b0);
      check_output("reset_conflict", conflict, 1'b0);
      check_output("reset_busy", busy, 1'b0);
      wait_until(4);
      rst = 1'b1;

      // Clean set press for 40 cycles: one s pulse, none on release.
      wait_until(10);
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      expect_pulse(K_S, c + LAT);
      wait_until(c + 40);
      apply_stimulus(1'b0, 1'b0);
      wait_until(c + 80);

      // Bouncy reset press 1,0,1,1,0 then held: pulse timed from the last rise.
      c = cyc;
      apply_stimulus(1'b0, 1'b1);
      wait_until(c + 1); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 2); apply_stimulus(1'b0, 1'b1);
      wait_until(c + 4); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 5); apply_stimulus(1'b0, 1'b1);
      expect_pulse(K_R, c + 5 + LAT);
      wait_until(c + 40);
      apply_stimulus(1'b0, 1'b0);
      wait_until(c + 80);

      // 10-cycle glitch on set: no pulse.
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      wait_until(c + 10);
      apply_stimulus(1'b0, 1'b0);
      wait_until(c + 50);

      // Press, 5-cycle release bounce, re-press: only the first pulse.
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      expect_pulse(K_S, c + LAT);
      wait_until(c + 30); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 35); apply_stimulus(1'b1, 1'b0);
      wait_until(c + 60); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 100);

      // Set, then reset two cycles later: s at P, r at P+HOLD+1.
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      wait_until(c + 2); apply_stimulus(1'b1, 1'b1);
      expect_pulse(K_S, c + LAT);
      expect_pulse(K_R, c + LAT + HOLD + 1);
      wait_until(c + 40); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 80);

      // Reset event lands in the cycle the holdoff drains: issued next cycle.
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      wait_until(c + 5); apply_stimulus(1'b1, 1'b1);
      expect_pulse(K_S, c + LAT);
      expect_pulse(K_R, c + 5 + LAT);
      wait_until(c + 40); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 80);

      // Both buttons on the same edge.
      c = cyc;
      apply_stimulus(1'b1, 1'b1);
`ifdef SR_RESET_PRIORITY_EN
      expect_pulse(K_R, c + LAT);
      expect_pulse(K_S, c + LAT + HOLD + 1);
`else
      expect_pulse(K_CONF, c + LAT);
`endif
      wait_until(c + 40); apply_stimulus(1'b0, 1'b0);
      wait_until(c + 80);

      // Reset mid-operation: s issued, reset pending in holdoff, then rst.
      c = cyc;
      apply_stimulus(1'b1, 1'b0);
      wait_until(c + 2); apply_stimulus(1'b1, 1'b1);
      expect_pulse(K_S, c + LAT);
      wait_until(c + LAT + 2);
      #1;
      rst = 1'b0;
      #1;
      check_output("midrst_s", s, 1'b0);
      check_output("midrst_r", r, 1'b0);
      check_output("midrst_conflict", conflict, 1'b0);
      check_output("midrst_busy", busy, 1'b0);
      apply_stimulus(1'b1, 1'b0);
      wait_until(c + LAT + 7);
      k = cyc;
      rst = 1'b1;
      // Set is still held: it must re-qualify from IDLE after release.
      expect_pulse(K_S, k + LAT);
      wait_until(k + 40); apply_stimulus(1'b0, 1'b0);
      wait_until(k + 80);

      // Every expected pulse must have been seen.
      tests_run++;
      if (expq.size() != 0) begin
         tests_failed++;
         while (expq.size() != 0) begin
            mon_e = expq.pop_front();
            $display("[TB] FAIL missing_pulse: got none, required %s at cycle %0d",
                     kind_name(mon_e.kind), mon_e.cyc);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
